// File: rtl/alu_pkg.sv
// Shared encodings for alu_pipe: operation-select fields, full opcodes and FSM states.
// S[0] picks arithmetic vs. the rest, S[1] picks logic vs. compare, S[3:2] picks the sub-op.
package alu_pkg;

  localparam logic [1:0] SUB_ADD = 2'b00;
  localparam logic [1:0] SUB_SUB = 2'b01;
  localparam logic [1:0] SUB_INC = 2'b10;
  localparam logic [1:0] SUB_MUL = 2'b11;

  localparam logic [1:0] SUB_AND = 2'b00;
  localparam logic [1:0] SUB_OR  = 2'b01;
  localparam logic [1:0] SUB_XOR = 2'b10;
  localparam logic [1:0] SUB_NOT = 2'b11;

  localparam logic [1:0] SUB_EQ  = 2'b00;
  localparam logic [1:0] SUB_GT  = 2'b01;
  localparam logic [1:0] SUB_LT  = 2'b10;
  localparam logic [1:0] SUB_MAX = 2'b11;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_INC = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1100;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b1001;
  localparam logic [3:0] OP_NOT = 4'b1101;
  localparam logic [3:0] OP_EQ  = 4'b0011;
  localparam logic [3:0] OP_GT  = 4'b0111;
  localparam logic [3:0] OP_LT  = 4'b1011;
  localparam logic [3:0] OP_MAX = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_HOLD
  } state_t;

  function automatic logic isMulOp(input logic [3:0] s);
    return (s[0] == 1'b0) && (s[3:2] == SUB_MUL);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one bit of the multiplier per cycle after i_start.
// o_done and o_prod are combinational in the cycle of the final iteration.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_prod
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_prodNext;

  assign w_prodNext = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign o_done     = r_busy && (r_cnt == CW'(WIDTH - 1));
  assign o_prod     = w_prodNext;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_prod   <= w_prodNext;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle arithmetic/logic/compare ops, multi-cycle multiply,
// and an accumulator that can stand in for operand A.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       S,
  input  logic             ACC_EN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] F_HI,
  output logic             C_OUT,
  output logic             ZERO
);

  state_t             r_state;
  state_t             w_nextState;
  logic [WIDTH-1:0]   r_f;
  logic [WIDTH-1:0]   r_fHi;
  logic [WIDTH-1:0]   r_acc;
  logic               r_cOut;
  logic               r_outValid;
  logic               w_accept;
  logic               w_isMul;
  logic               w_mulStart;
  logic               w_mulDone;
  logic [WIDTH-1:0]   w_opA;
  logic [WIDTH-1:0]   w_aluF;
  logic               w_aluC;
  logic [2*WIDTH-1:0] w_prod;

  assign IN_READY   = (r_state == ST_IDLE) && (!r_outValid || OUT_READY);
  assign w_accept   = IN_VALID && IN_READY;
  assign w_isMul    = isMulOp(S);
  assign w_mulStart = w_accept && w_isMul;
  assign w_opA      = ACC_EN ? r_acc : A;

  assign OUT_VALID = r_outValid;
  assign F         = r_f;
  assign F_HI      = r_fHi;
  assign C_OUT     = r_cOut;
  assign ZERO      = (r_f == '0);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_start (w_mulStart),
    .i_a     (w_opA),
    .i_b     (B),
    .o_done  (w_mulDone),
    .o_prod  (w_prod)
  );

  always_comb begin
    w_aluF = '0;
    w_aluC = 1'b0;
    if (!S[0]) begin
      case (S[3:2])
        SUB_ADD: {w_aluC, w_aluF} = {1'b0, w_opA} + {1'b0, B};
        SUB_SUB: begin
          w_aluF = w_opA - B;
          w_aluC = (w_opA < B);
        end
        SUB_INC: {w_aluC, w_aluF} = {1'b0, w_opA} + {{WIDTH{1'b0}}, 1'b1};
        default: ;
      endcase
    end else if (!S[1]) begin
      case (S[3:2])
        SUB_AND: w_aluF = w_opA & B;
        SUB_OR:  w_aluF = w_opA | B;
        SUB_XOR: w_aluF = w_opA ^ B;
        default: w_aluF = ~w_opA;
      endcase
    end else begin
      case (S[3:2])
        SUB_EQ:  w_aluF = {{(WIDTH-1){1'b0}}, (w_opA == B)};
        SUB_GT:  w_aluF = {{(WIDTH-1){1'b0}}, (w_opA > B)};
        SUB_LT:  w_aluF = {{(WIDTH-1){1'b0}}, (w_opA < B)};
        default: w_aluF = (w_opA > B) ? w_opA : B;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (w_mulStart) w_nextState = ST_MUL;
      ST_MUL:  if (w_mulDone)  w_nextState = OUT_READY ? ST_IDLE : ST_HOLD;
      ST_HOLD: if (OUT_READY)  w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Result register doubles as the accumulator source; it only moves on production or hand-off.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_f        <= '0;
      r_fHi      <= '0;
      r_cOut     <= 1'b0;
      r_outValid <= 1'b0;
      r_acc      <= '0;
    end else if (w_accept && !w_isMul) begin
      r_f        <= w_aluF;
      r_fHi      <= '0;
      r_cOut     <= w_aluC;
      r_outValid <= 1'b1;
      r_acc      <= w_aluF;
    end else if (w_mulDone) begin
      r_f        <= w_prod[WIDTH-1:0];
      r_fHi      <= w_prod[2*WIDTH-1:WIDTH];
      r_cOut     <= |w_prod[2*WIDTH-1:WIDTH];
      r_outValid <= 1'b1;
      r_acc      <= w_prod[WIDTH-1:0];
    end else if (r_outValid && OUT_READY) begin
      r_outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): directed vectors with literal expectations
// plus a queue-based reference model compared against the outputs every cycle.
module tb_alu_pipe;

  localparam int W = 8;

  localparam logic [3:0] T_ADD = 4'b0000;
  localparam logic [3:0] T_SUB = 4'b0100;
  localparam logic [3:0] T_INC = 4'b1000;
  localparam logic [3:0] T_MUL = 4'b1100;
  localparam logic [3:0] T_AND = 4'b0001;
  localparam logic [3:0] T_OR  = 4'b0101;
  localparam logic [3:0] T_XOR = 4'b1001;
  localparam logic [3:0] T_NOT = 4'b1101;
  localparam logic [3:0] T_EQ  = 4'b0011;
  localparam logic [3:0] T_GT  = 4'b0111;
  localparam logic [3:0] T_LT  = 4'b1011;
  localparam logic [3:0] T_MAX = 4'b1111;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         inVal = 1'b0;
  logic         inReady;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   s = '0;
  logic         accEn = 1'b0;
  logic         outValid;
  logic         outRdy = 1'b1;
  logic [W-1:0] fOut;
  logic [W-1:0] fHi;
  logic         cOut;
  logic         zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] f;
    logic [W-1:0] hi;
    logic         c;
    int           due;
  } exp_t;

  exp_t         expQ[$];
  logic [W-1:0] macc = '0;
  int           cyc = 0;
  bit           prevTaken = 1'b1;

  alu_pipe #(.WIDTH(W)) dut (
    .CLK       (clk),
    .RST       (rst),
    .IN_VALID  (inVal),
    .IN_READY  (inReady),
    .A         (a),
    .B         (b),
    .S         (s),
    .ACC_EN    (accEn),
    .OUT_VALID (outValid),
    .OUT_READY (outRdy),
    .F         (fOut),
    .F_HI      (fHi),
    .C_OUT     (cOut),
    .ZERO      (zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t r;
    logic [2*W-1:0] p;
    r.f = '0; r.hi = '0; r.c = 1'b0; r.due = 0;
    p = '0;
    if (op == T_ADD)      begin p = {8'h00, x} + {8'h00, y}; r.f = p[W-1:0]; r.c = p[W]; end
    else if (op == T_SUB) begin r.f = x - y; r.c = (x < y); end
    else if (op == T_INC) begin r.f = x + 8'd1; r.c = (x == 8'hFF); end
    else if (op == T_MUL) begin p = {8'h00, x} * {8'h00, y}; r.f = p[W-1:0]; r.hi = p[2*W-1:W]; r.c = (r.hi != 0); end
    else if (op == T_AND) r.f = x & y;
    else if (op == T_OR)  r.f = x | y;
    else if (op == T_XOR) r.f = x ^ y;
    else if (op == T_NOT) r.f = ~x;
    else if (op == T_EQ)  r.f = (x == y) ? 8'd1 : 8'd0;
    else if (op == T_GT)  r.f = (x > y) ? 8'd1 : 8'd0;
    else if (op == T_LT)  r.f = (x < y) ? 8'd1 : 8'd0;
    else                  r.f = (x > y) ? x : y;
    return r;
  endfunction

  // Reference model: predicts each accepted request and checks every cycle a result is shown.
  always @(negedge clk) begin
    exp_t e;
    bit   taken;
    cyc++;
    if (rst) begin
      expQ.delete();
      macc = '0;
      prevTaken = 1'b1;
    end else begin
      if (outValid) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL model_spurious: got valid F=%h with no request outstanding", fOut);
        end else begin
          e = expQ[0];
          if (fOut !== e.f || fHi !== e.hi || cOut !== e.c || zero !== (e.f == 0)) begin
            bad++;
            $display("[TB] FAIL model_result: got F=%h HI=%h C=%b Z=%b want F=%h HI=%h C=%b Z=%b",
                     fOut, fHi, cOut, zero, e.f, e.hi, e.c, (e.f == 0));
          end else if (prevTaken && cyc != e.due) begin
            bad++;
            $display("[TB] FAIL model_latency: result at cycle %0d want cycle %0d", cyc, e.due);
          end
        end
      end else if (expQ.size() > 0 && cyc >= expQ[0].due) begin
        total++;
        bad++;
        $display("[TB] FAIL model_late: no result at cycle %0d want by cycle %0d", cyc, expQ[0].due);
        void'(expQ.pop_front());
      end
      taken = outValid && outRdy;
      if (taken && expQ.size() > 0) void'(expQ.pop_front());
      prevTaken = !outValid || taken;
      if (inVal && inReady) begin
        e = model(s, accEn ? macc : a, b);
        e.due = cyc + ((s == T_MUL) ? W + 1 : 1);
        macc = e.f;
        expQ.push_back(e);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] ef, input logic [W-1:0] eh,
                             input logic ec, input logic ez, input logic ev);
    total++;
    if ({outValid, fOut, fHi, cOut, zero} !== {ev, ef, eh, ec, ez}) begin
      bad++;
      $display("[TB] FAIL %s: got V=%b F=%h HI=%h C=%b Z=%b want V=%b F=%h HI=%h C=%b Z=%b",
               name, outValid, fOut, fHi, cOut, zero, ev, ef, eh, ec, ez);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %b want %b", name, act, expv);
    end
  endtask

  // Presents one request and returns just after the edge that accepted it.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                               input logic en);
    bit got = 1'b0;
    @(posedge clk); #1;
    s = op; a = va; b = vb; accEn = en; inVal = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (inReady) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("[TB] FAIL accept_timeout: got no IN_READY in 200 cycles want accept");
    end
    @(posedge clk); #1;
    inVal = 1'b0; a = 8'hA5; b = 8'h3C; s = 4'b0110; accEn = 1'b0;
  endtask

  task automatic runOp(input string name, input logic [3:0] op, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic en, input logic [W-1:0] ef, input logic ec);
    applyStimulus(op, va, vb, en);
    @(negedge clk);
    checkOutput(name, ef, 8'h00, ec, (ef == 8'h00), 1'b1);
  endtask

  task automatic runMul(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
    applyStimulus(T_MUL, va, vb, 1'b0);
    for (int i = 1; i <= W + 1; i++) begin
      @(negedge clk);
      if (i <= W) begin
        checkBit({name, "_busy_valid"}, outValid, 1'b0);
        checkBit({name, "_busy_ready"}, inReady, 1'b0);
      end
    end
    checkOutput(name, el, eh, (eh != 8'h00), (el == 8'h00), 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test want finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_state", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    checkBit("reset_ready", inReady, 1'b1);

    runOp("add_ff_01", T_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    runOp("sub_03_05", T_SUB, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
    runOp("max_03_05", T_MAX, 8'h03, 8'h05, 1'b0, 8'h05, 1'b0);
    runOp("and_c3_0f", T_AND, 8'hC3, 8'h0F, 1'b0, 8'h03, 1'b0);
    runOp("or_c0_0f",  T_OR,  8'hC0, 8'h0F, 1'b0, 8'hCF, 1'b0);
    runOp("not_0f",    T_NOT, 8'h0F, 8'h77, 1'b0, 8'hF0, 1'b0);
    runOp("eq_07_07",  T_EQ,  8'h07, 8'h07, 1'b0, 8'h01, 1'b0);
    runOp("gt_03_05",  T_GT,  8'h03, 8'h05, 1'b0, 8'h00, 1'b0);
    runOp("lt_03_05",  T_LT,  8'h03, 8'h05, 1'b0, 8'h01, 1'b0);
    runOp("inc_ff",    T_INC, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1);
    runOp("sub_09_09", T_SUB, 8'h09, 8'h09, 1'b0, 8'h00, 1'b0);

    runMul("mul_ff_ff", 8'hFF, 8'hFF, 8'hFE, 8'h01);
    runMul("mul_00_ff", 8'h00, 8'hFF, 8'h00, 8'h00);

    runOp("acc_seed_add", T_ADD, 8'h10, 8'h01, 1'b0, 8'h11, 1'b0);
    runOp("acc_inc",      T_INC, 8'h77, 8'h00, 1'b1, 8'h12, 1'b0);

    // Back-pressure on a single-cycle result with a request waiting behind it.
    @(posedge clk); #1 outRdy = 1'b0;
    applyStimulus(T_ADD, 8'h20, 8'h22, 1'b0);
    s = T_XOR; a = 8'h5A; b = 8'h0F; accEn = 1'b0; inVal = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_add", 8'h42, 8'h00, 1'b0, 1'b0, 1'b1);
      checkBit("hold_ready", inReady, 1'b0);
    end
    @(posedge clk); #1 outRdy = 1'b1;
    @(negedge clk);
    checkBit("release_ready", inReady, 1'b1);
    @(posedge clk); #1 inVal = 1'b0;
    @(negedge clk);
    checkOutput("xor_back_to_back", 8'h55, 8'h00, 1'b0, 1'b0, 1'b1);

    // Multiply result parked in HOLD.
    @(posedge clk); #1 outRdy = 1'b0;
    runMul("mul_03_05_hold", 8'h03, 8'h05, 8'h00, 8'h0F);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("mul_hold", 8'h0F, 8'h00, 1'b0, 1'b0, 1'b1);
      checkBit("mul_hold_ready", inReady, 1'b0);
    end
    @(posedge clk); #1 outRdy = 1'b1;
    @(negedge clk);

    // Reset in the middle of a multiply.
    applyStimulus(T_MUL, 8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_mul", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    checkBit("rst_mid_mul_ready", inReady, 1'b1);
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      checkBit("rst_no_result", outValid, 1'b0);
    end
    runOp("acc_after_rst", T_INC, 8'h55, 8'h00, 1'b1, 8'h01, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port IN_VALID  input  1  operation request present.
REQ-005 SHALL have port IN_READY  output  1  block accepts request this cycle.
REQ-006 SHALL have port A  input  WIDTH  operand A (unsigned).
REQ-007 SHALL have port B  input  WIDTH  operand B (unsigned).
REQ-008 SHALL have port S  input  4  operation select (encoding per REQ-013..016).
REQ-009 SHALL have port ACC_EN  input  1  substitute internal accumulator for A.
REQ-010 SHALL have port OUT_VALID  output  1  result present on F/F_HI/flags.
REQ-011 SHALL have port OUT_READY  input  1  consumer takes result this cycle.
REQ-012 SHALL have ports F  output  WIDTH  result low; F_HI  output  WIDTH  MUL upper half, 0 otherwise; C_OUT  output  1  carry/borrow; ZERO  output  1  F==0.

Function
REQ-013 Unit select: S[0]=0 arithmetic; S[0]=1,S[1]=0 logic; S[0]=1,S[1]=1 compare; S[3:2] picks sub-op.
REQ-014 Arithmetic S[3:2]: 00 ADD A+B, C_OUT=carry; 01 SUB A-B mod 2^WIDTH, C_OUT=1 iff A<B; 10 INC A+1, C_OUT=1 iff A all-ones (F wraps to 0); 11 MUL, {F_HI,F}=A*B, C_OUT=1 iff F_HI!=0.
REQ-015 Logic S[3:2]: 00 AND, 01 OR, 10 XOR, 11 NOT A; C_OUT=0.
REQ-016 Compare S[3:2]: 00 EQ, 01 A>B, 10 A<B (F=1/0 zero-extended); 11 MAX(A,B); C_OUT=0.
REQ-017 Request accepted on cycle where IN_VALID & IN_READY; operands, S, ACC_EN captured that edge; later input changes ignored.
REQ-018 FSM states IDLE, MUL, HOLD; RST -> IDLE.
REQ-019 IDLE: IN_READY = !OUT_VALID | OUT_READY; non-MUL accept -> result registered, OUT_VALID=1 next cycle (latency 1), stay IDLE; MUL accept -> MUL.
REQ-020 MUL: IN_READY=0; shift-add one bit of B per cycle, WIDTH iterations; OUT_VALID rises exactly WIDTH cycles after accept edge; then HOLD if OUT_READY=0 else IDLE.
REQ-021 HOLD: IN_READY=0 until OUT_READY=1, then IDLE.
REQ-022 While OUT_VALID=1 and OUT_READY=0, F, F_HI, C_OUT, ZERO SHALL hold stable.
REQ-023 OUT_VALID clears the cycle after OUT_READY=1 unless a new non-MUL op is accepted that same cycle (back-to-back, throughput 1/cycle).
REQ-024 Accumulator ACC (WIDTH) SHALL load F on every result production; ACC_EN=1 at accept uses ACC as A.
REQ-025 ZERO SHALL reflect F only (F_HI ignored).

Reset
REQ-026 RST SHALL override all other inputs, including during MUL (operation aborted, no result emitted).
REQ-027 After RST: OUT_VALID=0, F=0, F_HI=0, C_OUT=0, ZERO=1, ACC=0, state IDLE, IN_READY=1 the first cycle after RST deasserts.

Structure
REQ-028 Package alu_pkg SHALL hold unit/sub-op S encodings as named constants and the FSM state enum.
REQ-029 Multiplier SHALL be sub-module alu_mul_seq (start, done, WIDTH param); remaining datapath inline.

Verification
REQ-030 WIDTH=8: ADD A=0xFF,B=0x01 -> F=0x00, C_OUT=1, ZERO=1, OUT_VALID 1 cycle after accept.
REQ-031 WIDTH=8: SUB A=0x03,B=0x05 -> F=0xFE, C_OUT=1; MAX A=0x03,B=0x05 -> F=0x05, C_OUT=0.
REQ-032 WIDTH=8: MUL A=0xFF,B=0xFF -> F_HI=0xFE, F=0x01, C_OUT=1, OUT_VALID exactly 8 cycles after accept, IN_READY=0 throughout.
REQ-033 OUT_READY held 0 for 5 cycles after a result -> outputs stable, IN_READY=0, following request accepted only after OUT_READY=1.
REQ-034 ADD 0x10+0x01, then ACC_EN=1 INC -> F=0x12; RST asserted mid-MUL -> OUT_VALID=0, ACC=0, IN_READY=1 next cycle.
